// File: rtl/celery_pkg.sv
// ----------------------------------------------------------------------------
// celery_pkg
//  Shared types and helpers for the celery pixel pipeline.
//  - fragment_t   : rasterizer output record (valid, x, y, z S15.16, color)
//  - depth16_t    : 16-bit Z-buffer depth word
//  - depth_func_t : depth/stencil/alpha comparison operator (z_new OP z_buf)
//  - dt_state_t   : depth-test FSM state, exported on the debug port
//  - fp_to_depth16() : S15.16 z -> 16-bit depth with clamping
//  - depth_cmp()     : unsigned compare under a depth_func_t
//  Optional build macro used by celery_depth_test: CELERY_DEPTH_BIAS_EN.
// ----------------------------------------------------------------------------
package celery_pkg;

  typedef logic [15:0] depth16_t;

  // 1.0 in S15.16
  localparam logic [31:0] FP_ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    DF_NEVER    = 3'd0,
    DF_LESS     = 3'd1,
    DF_EQUAL    = 3'd2,
    DF_LEQUAL   = 3'd3,
    DF_GREATER  = 3'd4,
    DF_NOTEQUAL = 3'd5,
    DF_GEQUAL   = 3'd6,
    DF_ALWAYS   = 3'd7
  } depth_func_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] z;      // S15.16, 0 = near, 1.0 = far
    logic [31:0] color;
  } fragment_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_WR      = 3'd5,
    ST_EMIT    = 3'd6
  } dt_state_t;

  // Negative z clamps to the near plane, z >= 1.0 clamps to the far plane;
  // in between the fractional bits are the depth.
  function automatic depth16_t fp_to_depth16(input logic [31:0] z);
    depth16_t d;
    if (z[31])             d = 16'h0000;
    else if (z >= FP_ONE)  d = 16'hFFFF;
    else                   d = z[15:0];
    return d;
  endfunction

  function automatic logic depth_cmp(input depth_func_t f, input depth16_t a,
                                     input depth16_t b);
    logic r;
    case (f)
      DF_NEVER:    r = 1'b0;
      DF_LESS:     r = (a <  b);
      DF_EQUAL:    r = (a == b);
      DF_LEQUAL:   r = (a <= b);
      DF_GREATER:  r = (a >  b);
      DF_NOTEQUAL: r = (a != b);
      DF_GEQUAL:   r = (a >= b);
      default:     r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/celery_depth_cmp.sv
// ----------------------------------------------------------------------------
// celery_depth_cmp
//  Combinational comparator: o_pass = i_z_new OP i_z_buf (unsigned, 16 bit).
//  Kept as its own block so the stencil and alpha tests can reuse it.
//  Ports:
//    i_func  : comparison operator
//    i_z_new : incoming depth
//    i_z_buf : stored depth
//    o_pass  : comparison result
// ----------------------------------------------------------------------------
module celery_depth_cmp
  import celery_pkg::*;
(
  input  depth_func_t i_func,
  input  depth16_t    i_z_new,
  input  depth16_t    i_z_buf,
  output logic        o_pass
);

  assign o_pass = depth_cmp(i_func, i_z_new, i_z_buf);

endmodule

// File: rtl/celery_depth_test.sv
// ----------------------------------------------------------------------------
// celery_depth_test
//  Per-fragment depth test between the rasterizer and texture/blend. One
//  fragment in flight: capture -> bounds/config check -> Z read -> compare ->
//  optional Z write -> emit. Dropped fragments (invalid, off-screen, test
//  fail) bump fail_count; emitted fragments bump pass_count.
//
//  Handshakes: every interface is valid/ready. A beat transfers on a rising
//  edge where valid and ready are both high. A valid, once raised, stays high
//  with a stable payload until that transfer; every payload here comes from
//  registers that only change at fragment capture, which guarantees this.
//
//  Ports:
//    clk, rst                      clock, synchronous active-high reset
//    frag_valid/ready, frag_in     fragment input
//    out_valid/ready, out_frag     passing fragment output
//    zb_rd_valid/ready, zb_rd_addr Z-buffer read request
//    zb_rsp_valid, zb_rsp_data     Z-buffer read response
//    zb_wr_valid/ready, addr, data Z-buffer write request
//    depth_enable, depth_func, depth_write_en   per-fragment config
//    depth_bias                    signed bias (only with CELERY_DEPTH_BIAS_EN)
//    pass_count, fail_count        wrapping 32-bit statistics
//    o_dbg_state                   current FSM state
//  Build macro: CELERY_DEPTH_BIAS_EN adds depth_bias, applied with
//  saturation to the converted depth before compare and write.
// ----------------------------------------------------------------------------
module celery_depth_test
  import celery_pkg::*;
#(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int ZB_ADDR_W = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frag_valid,
  output logic                 frag_ready,
  input  fragment_t            frag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output fragment_t            out_frag,
  output logic                 zb_rd_valid,
  input  logic                 zb_rd_ready,
  output logic [ZB_ADDR_W-1:0] zb_rd_addr,
  input  logic                 zb_rsp_valid,
  input  logic [15:0]          zb_rsp_data,
  output logic                 zb_wr_valid,
  input  logic                 zb_wr_ready,
  output logic [ZB_ADDR_W-1:0] zb_wr_addr,
  output logic [15:0]          zb_wr_data,
  input  logic                 depth_enable,
  input  depth_func_t          depth_func,
  input  logic                 depth_write_en,
`ifdef CELERY_DEPTH_BIAS_EN
  input  logic signed [15:0]   depth_bias,
`endif
  output logic [31:0]          pass_count,
  output logic [31:0]          fail_count,
  output dt_state_t            o_dbg_state
);

  localparam logic [15:0] SCREEN_W16 = 16'(SCREEN_W);
  localparam logic [15:0] SCREEN_H16 = 16'(SCREEN_H);

  dt_state_t             r_state, w_next_state;
  fragment_t             r_frag;
  logic                  r_en, r_wen, r_in_bounds;
  depth_func_t           r_func;
  logic [ZB_ADDR_W-1:0]  r_addr;
  depth16_t              r_z_new, r_z_buf;
  logic [31:0]           r_pass_count, r_fail_count;

  logic                  w_capture, w_in_bounds, w_pass;
  logic                  w_pass_evt, w_fail_evt;
  logic [ZB_ADDR_W-1:0]  w_addr;
  depth16_t              w_z_conv, w_z_new;

  // Input-side datapath, evaluated on the fragment being captured
  assign w_in_bounds = (frag_in.x < SCREEN_W16) && (frag_in.y < SCREEN_H16);
  assign w_addr      = ZB_ADDR_W'(frag_in.y) * ZB_ADDR_W'(SCREEN_W)
                     + ZB_ADDR_W'(frag_in.x);
  assign w_z_conv    = fp_to_depth16(frag_in.z);

`ifdef CELERY_DEPTH_BIAS_EN
  // 18-bit signed sum: bit 17 flags underflow, bit 16 flags overflow.
  logic signed [17:0] w_biased;
  assign w_biased = $signed({2'b00, w_z_conv})
                  + $signed({{2{depth_bias[15]}}, depth_bias});
  always_comb begin
    if (w_biased[17])      w_z_new = 16'h0000;
    else if (w_biased[16]) w_z_new = 16'hFFFF;
    else                   w_z_new = w_biased[15:0];
  end
`else
  assign w_z_new = w_z_conv;
`endif

  celery_depth_cmp u_cmp (
    .i_func  (r_func),
    .i_z_new (r_z_new),
    .i_z_buf (r_z_buf),
    .o_pass  (w_pass)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (frag_valid) w_next_state = ST_CHECK;
      ST_CHECK: begin
        if (!r_frag.valid || !r_in_bounds)   w_next_state = ST_IDLE;
        else if (!r_en || r_func == DF_ALWAYS) w_next_state = ST_EMIT;
        else if (r_func == DF_NEVER)         w_next_state = ST_IDLE;
        else                                 w_next_state = ST_RD_REQ;
      end
      ST_RD_REQ:  if (zb_rd_ready)  w_next_state = ST_RD_WAIT;
      ST_RD_WAIT: if (zb_rsp_valid) w_next_state = ST_DECIDE;
      ST_DECIDE: begin
        if (!w_pass)    w_next_state = ST_IDLE;
        else if (r_wen) w_next_state = ST_WR;
        else            w_next_state = ST_EMIT;
      end
      ST_WR:      if (zb_wr_ready)  w_next_state = ST_EMIT;
      ST_EMIT:    if (out_ready)    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs and statistic events
  always_comb begin
    frag_ready  = 1'b0;
    zb_rd_valid = 1'b0;
    zb_wr_valid = 1'b0;
    out_valid   = 1'b0;
    w_capture   = 1'b0;
    w_pass_evt  = 1'b0;
    w_fail_evt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        frag_ready = 1'b1;
        w_capture  = frag_valid;
      end
      ST_CHECK: w_fail_evt = !r_frag.valid || !r_in_bounds
                          || (r_en && r_func == DF_NEVER);
      ST_RD_REQ: zb_rd_valid = 1'b1;
      ST_DECIDE: w_fail_evt  = !w_pass;
      ST_WR:     zb_wr_valid = 1'b1;
      ST_EMIT: begin
        out_valid  = 1'b1;
        w_pass_evt = out_ready;
      end
      default: ;
    endcase
  end

  // Fragment and config are frozen at capture; the stored depth is latched
  // only while a response is expected, so stale responses have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frag      <= '0;
      r_en        <= 1'b0;
      r_wen       <= 1'b0;
      r_func      <= DF_NEVER;
      r_in_bounds <= 1'b0;
      r_addr      <= '0;
      r_z_new     <= '0;
      r_z_buf     <= '0;
    end else begin
      if (w_capture) begin
        r_frag      <= frag_in;
        r_en        <= depth_enable;
        r_wen       <= depth_write_en;
        r_func      <= depth_func;
        r_in_bounds <= w_in_bounds;
        r_addr      <= w_addr;
        r_z_new     <= w_z_new;
      end
      if (r_state == ST_RD_WAIT && zb_rsp_valid) r_z_buf <= zb_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_count <= '0;
      r_fail_count <= '0;
    end else begin
      if (w_pass_evt) r_pass_count <= r_pass_count + 32'd1;
      if (w_fail_evt) r_fail_count <= r_fail_count + 32'd1;
    end
  end

  assign out_frag    = r_frag;
  assign zb_rd_addr  = r_addr;
  assign zb_wr_addr  = r_addr;
  assign zb_wr_data  = r_z_new;
  assign pass_count  = r_pass_count;
  assign fail_count  = r_fail_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_celery_depth_test.sv
// ----------------------------------------------------------------------------
// tb_celery_depth_test
//  Directed bench for celery_depth_test: vector table of single fragments
//  plus hand sequences for latency, off-screen turnaround, backpressure and
//  reset during a pending read. A memory process answers reads after a
//  programmable delay and records every accepted read/write/output beat.
// ----------------------------------------------------------------------------
module tb_celery_depth_test;
  import celery_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk, rst;
  logic        frag_valid, frag_ready;
  fragment_t   frag_in, out_frag;
  logic        out_valid, out_ready;
  logic        zb_rd_valid, zb_rd_ready;
  logic [18:0] zb_rd_addr, zb_wr_addr;
  logic        zb_rsp_valid;
  logic [15:0] zb_rsp_data, zb_wr_data;
  logic        zb_wr_valid, zb_wr_ready;
  logic        depth_enable, depth_write_en;
  depth_func_t depth_func;
  logic [31:0] pass_count, fail_count;
  dt_state_t   o_dbg_state;
`ifdef CELERY_DEPTH_BIAS_EN
  logic signed [15:0] depth_bias;
  initial depth_bias = '0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  celery_depth_test dut (
    .clk(clk), .rst(rst),
    .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_in(frag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_frag(out_frag),
    .zb_rd_valid(zb_rd_valid), .zb_rd_ready(zb_rd_ready), .zb_rd_addr(zb_rd_addr),
    .zb_rsp_valid(zb_rsp_valid), .zb_rsp_data(zb_rsp_data),
    .zb_wr_valid(zb_wr_valid), .zb_wr_ready(zb_wr_ready),
    .zb_wr_addr(zb_wr_addr), .zb_wr_data(zb_wr_data),
    .depth_enable(depth_enable), .depth_func(depth_func),
    .depth_write_en(depth_write_en),
`ifdef CELERY_DEPTH_BIAS_EN
    .depth_bias(depth_bias),
`endif
    .pass_count(pass_count), .fail_count(fail_count),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  logic [34:0] exp_q[$];   // expected writes {addr, data}
  logic [34:0] got_q[$];   // observed writes, filled by the memory process
  int got_rd = 0;

  // memory-side model (written only by the memory process)
  int          rd_cnt = 0, wr_cnt = 0, out_cnt = 0, pend = 0;
  logic [18:0] last_rd_addr = '0;
  fragment_t   last_out = '0;
  logic        rd_acc;
  // memory configuration (written only by the main process)
  int          rsp_delay = 1;
  logic [15:0] zbuf_val = '0;

  // ---------------- memory responder / monitor ----------------
  initial begin
    zb_rsp_valid = 1'b0;
    zb_rsp_data  = '0;
    forever begin
      @(negedge clk);
      rd_acc = zb_rd_valid && zb_rd_ready && !rst;
      if (rd_acc) begin
        rd_cnt++;
        last_rd_addr = zb_rd_addr;
      end
      if (zb_wr_valid && zb_wr_ready && !rst) begin
        wr_cnt++;
        got_q.push_back({zb_wr_addr, zb_wr_data});
      end
      if (out_valid && out_ready && !rst) begin
        out_cnt++;
        last_out = out_frag;
      end
      @(posedge clk);
      #1;
      if (rd_acc) pend = rsp_delay;
      if (pend == 1) begin
        zb_rsp_valid = 1'b1;
        zb_rsp_data  = zbuf_val;
        pend = 0;
      end else begin
        zb_rsp_valid = 1'b0;
        if (pend > 1) pend--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic fragment_t mk_frag(input logic v, input logic [15:0] x,
                                        input logic [15:0] y, input logic [31:0] z);
    fragment_t f;
    f.valid = v;
    f.x     = x;
    f.y     = y;
    f.z     = z;
    f.color = {x, y} ^ 32'hA5A5_5A5A;
    return f;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at capture edge +1.
  // Config is scrambled after capture to show it is held per fragment.
  task automatic apply_frag(input fragment_t f, input logic en,
                            input depth_func_t fn, input logic wen);
    frag_in        = f;
    depth_enable   = en;
    depth_func     = fn;
    depth_write_en = wen;
    frag_valid     = 1'b1;
    @(posedge clk);
    #1;
    frag_valid     = 1'b0;
    frag_in        = '0;
    depth_enable   = ~en;
    depth_func     = DF_NEVER;
    depth_write_en = ~wen;
  endtask

  task automatic wait_state(input dt_state_t s, input string nm);
    int n = 0;
    while (o_dbg_state != s && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 128'(o_dbg_state), 128'(s));
  endtask

  task automatic drain_writes(input string nm);
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      chk({nm, "_wr"}, 128'(got_q[got_rd]), 128'(exp_q.pop_front()));
      got_rd++;
    end
    chk({nm, "_wr_left"}, 128'(exp_q.size() + got_q.size() - got_rd), 128'(0));
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_pass_cnt"}, 128'(pass_count), 128'(exp_pass));
    chk({nm, "_fail_cnt"}, 128'(fail_count), 128'(exp_fail));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    fragment_t   frag;
    logic        en;
    depth_func_t fn;
    logic        wen;
    logic [15:0] zbuf;
    logic        exp_pass;
    logic        exp_rd;
    logic [18:0] exp_addr;
    logic        exp_wr;
    logic [15:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk_vec(input fragment_t f, input logic en, input depth_func_t fn,
                                  input logic wen, input logic [15:0] zb, input logic ep,
                                  input logic er, input logic [18:0] ea, input logic ew,
                                  input logic [15:0] ed);
    vec_t v;
    v.frag = f; v.en = en; v.fn = fn; v.wen = wen; v.zbuf = zb;
    v.exp_pass = ep; v.exp_rd = er; v.exp_addr = ea; v.exp_wr = ew; v.exp_wdata = ed;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    int rd0, wr0, out0;
    string nm;
    nm = $sformatf("v%0d", i);
    zbuf_val = v.zbuf;
    rd0 = rd_cnt; wr0 = wr_cnt; out0 = out_cnt;
    if (v.exp_wr) exp_q.push_back({v.exp_addr, v.exp_wdata});
    if (v.exp_pass) exp_pass++;
    else            exp_fail++;
    apply_frag(v.frag, v.en, v.fn, v.wen);
    wait_state(ST_IDLE, {nm, "_done"});
    chk({nm, "_rd_n"}, 128'(rd_cnt - rd0), 128'(v.exp_rd));
    if (v.exp_rd) chk({nm, "_rd_addr"}, 128'(last_rd_addr), 128'(v.exp_addr));
    chk({nm, "_wr_n"}, 128'(wr_cnt - wr0), 128'(v.exp_wr));
    chk({nm, "_out_n"}, 128'(out_cnt - out0), 128'(v.exp_pass));
    if (v.exp_pass) chk({nm, "_out_frag"}, 128'(last_out), 128'(v.frag));
    chk_counts(nm);
    drain_writes(nm);
  endtask

  vec_t tbl[16];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int rd0;
    fragment_t f;

    tbl[0]  = mk_vec(mk_frag(1, 10, 2, 32'h0000_4000), 1, DF_LESS, 1, 16'h8000,
                     1, 1, 19'd1290, 1, 16'h4000);
    tbl[1]  = mk_vec(mk_frag(1, 10, 2, 32'h0000_8000), 1, DF_LESS, 1, 16'h4000,
                     0, 1, 19'd1290, 0, 16'h0);
    tbl[2]  = mk_vec(mk_frag(1, 640, 0, 32'h0000_0100), 1, DF_LESS, 1, 16'h8000,
                     0, 0, 19'd0, 0, 16'h0);
    tbl[3]  = mk_vec(mk_frag(0, 1, 1, 32'h0000_0100), 1, DF_LESS, 1, 16'h8000,
                     0, 0, 19'd0, 0, 16'h0);
    tbl[4]  = mk_vec(mk_frag(1, 0, 480, 32'h0000_0100), 1, DF_LESS, 1, 16'h8000,
                     0, 0, 19'd0, 0, 16'h0);
    tbl[5]  = mk_vec(mk_frag(1, 639, 479, 32'h0001_8000), 1, DF_GEQUAL, 1, 16'hFFFF,
                     1, 1, 19'd307199, 1, 16'hFFFF);
    tbl[6]  = mk_vec(mk_frag(1, 0, 0, 32'hFFFF_FFFF), 1, DF_LEQUAL, 1, 16'h0000,
                     1, 1, 19'd0, 1, 16'h0000);
    tbl[7]  = mk_vec(mk_frag(1, 0, 0, 32'hFFFF_FFFF), 1, DF_GEQUAL, 1, 16'hFFFF,
                     0, 1, 19'd0, 0, 16'h0);
    tbl[8]  = mk_vec(mk_frag(1, 5, 5, 32'h0000_4000), 0, DF_NEVER, 1, 16'h0000,
                     1, 0, 19'd0, 0, 16'h0);
    tbl[9]  = mk_vec(mk_frag(1, 5, 5, 32'h0000_4000), 1, DF_NEVER, 1, 16'h0000,
                     0, 0, 19'd0, 0, 16'h0);
    tbl[10] = mk_vec(mk_frag(1, 5, 5, 32'h0000_4000), 1, DF_ALWAYS, 1, 16'h0000,
                     1, 0, 19'd0, 0, 16'h0);
    tbl[11] = mk_vec(mk_frag(1, 7, 7, 32'h0000_1234), 1, DF_EQUAL, 0, 16'h1234,
                     1, 1, 19'd4487, 0, 16'h0);
    tbl[12] = mk_vec(mk_frag(1, 7, 7, 32'h0000_1234), 1, DF_NOTEQUAL, 1, 16'h1234,
                     0, 1, 19'd4487, 0, 16'h0);
    tbl[13] = mk_vec(mk_frag(1, 3, 1, 32'h0000_1001), 1, DF_GREATER, 1, 16'h1000,
                     1, 1, 19'd643, 1, 16'h1001);
    tbl[14] = mk_vec(mk_frag(1, 100, 200, 32'h0001_0000), 1, DF_LESS, 1, 16'hFFFF,
                     0, 1, 19'd128100, 0, 16'h0);
    tbl[15] = mk_vec(mk_frag(1, 100, 200, 32'h0000_FFFF), 1, DF_LEQUAL, 1, 16'hFFFF,
                     1, 1, 19'd128100, 1, 16'hFFFF);

    // reset
    rst = 1'b1; frag_valid = 1'b0; frag_in = '0;
    out_ready = 1'b1; zb_rd_ready = 1'b1; zb_wr_ready = 1'b1;
    depth_enable = 1'b0; depth_func = DF_NEVER; depth_write_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_state", 128'(o_dbg_state), 128'(ST_IDLE));
    chk("rst_frag_ready", 128'(frag_ready), 128'(1));
    chk("rst_valids", 128'({out_valid, zb_rd_valid, zb_wr_valid}), 128'(0));
    chk_counts("rst");
    chk("rst_out_frag", 128'(out_frag), 128'(0));
    chk("rst_addr_data", 128'({zb_rd_addr, zb_wr_addr, zb_wr_data}), 128'(0));

    // table
    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // latency, depth enabled, zero-wait memory: out_valid 4 cycles after capture
    zbuf_val = 16'h8000;
    exp_pass++;
    apply_frag(mk_frag(1, 10, 2, 32'h0000_4000), 1, DF_LESS, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("lat_depth_en", 128'(n), 128'(4));
    wait_state(ST_IDLE, "lat_en_done");
    // latency with depth disabled: 1 cycle
    exp_pass++;
    apply_frag(mk_frag(1, 20, 3, 32'h0000_4000), 0, DF_LESS, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("lat_depth_dis", 128'(n), 128'(1));
    wait_state(ST_IDLE, "lat_dis_done");
    chk_counts("lat");

    // off-screen: ready drops only for the CHECK cycle, no memory traffic
    rd0 = rd_cnt;
    exp_fail++;
    apply_frag(mk_frag(1, 640, 10, 32'h0000_0100), 1, DF_LESS, 1);
    chk("offs_ready_low", 128'(frag_ready), 128'(0));
    @(posedge clk);
    #1;
    chk("offs_ready_back", 128'(frag_ready), 128'(1));
    chk("offs_no_rd", 128'(rd_cnt - rd0), 128'(0));
    chk_counts("offs");
    drain_writes("offs");

    // backpressure on all three outbound interfaces
    zb_rd_ready = 1'b0; zb_wr_ready = 1'b0; out_ready = 1'b0;
    zbuf_val = 16'h8000;
    f = mk_frag(1, 10, 2, 32'h0000_4000);
    exp_q.push_back({19'd1290, 16'h4000});
    exp_pass++;
    apply_frag(f, 1, DF_LESS, 1);
    wait_state(ST_RD_REQ, "bp_reach_rd");
    for (int k = 0; k < 5; k++) begin
      chk("bp_rd_hold", 128'({zb_rd_valid, zb_rd_addr}), 128'({1'b1, 19'd1290}));
      @(posedge clk); #1;
    end
    zb_rd_ready = 1'b1;
    wait_state(ST_WR, "bp_reach_wr");
    for (int k = 0; k < 5; k++) begin
      chk("bp_wr_hold", 128'({zb_wr_valid, out_valid, zb_wr_addr, zb_wr_data}),
          128'({1'b1, 1'b0, 19'd1290, 16'h4000}));
      @(posedge clk); #1;
    end
    zb_wr_ready = 1'b1;
    wait_state(ST_EMIT, "bp_reach_emit");
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_hold", 128'({out_valid, out_frag}), 128'({1'b1, f}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_state(ST_IDLE, "bp_done");
    chk("bp_out_frag", 128'(last_out), 128'(f));
    chk_counts("bp");
    drain_writes("bp");

    // reset while waiting for read data; the late response must be ignored
    rsp_delay = 4;
    zbuf_val = 16'h8000;
    rd0 = out_cnt;
    apply_frag(mk_frag(1, 10, 2, 32'h0000_4000), 1, DF_LESS, 1);
    wait_state(ST_RD_WAIT, "rstw_reach");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    for (int k = 0; k < 6; k++) begin
      chk("rstw_idle", 128'({o_dbg_state, out_valid, zb_rd_valid, zb_wr_valid}),
          128'({ST_IDLE, 3'b000}));
      @(posedge clk); #1;
    end
    chk("rstw_no_out", 128'(out_cnt - rd0), 128'(0));
    chk_counts("rstw");
    drain_writes("rstw");

    // recovery after reset
    rsp_delay = 1;
    run_vec(100, tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
